// File: rtl/restoring_divider_if.sv
// Start/done handshake and operand/result bundle between the control unit
// (master) and the iterative restoring divider (slave).
interface restoring_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider.sv
// Iterative N-bit unsigned restoring divider: one trial subtraction per cycle,
// quotient and remainder registered on entry to DONE.
module restoring_divider #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    restoring_divider_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e        state_q;
    logic [N-1:0]  d_q;
    logic [N-1:0]  q_q;
    logic [N:0]    r_q;
    logic [CW-1:0] count_q;
    logic [N-1:0]  quotient_q;
    logic [N-1:0]  remainder_q;
    logic          div_by_zero_q;
    logic          busy_q;
    logic          done_q;

    logic [N:0]    rem_shift;
    logic [N+1:0]  trial_sum;
    logic          no_borrow;
    logic [N:0]    r_d;
    logic [N-1:0]  q_d;

    // Trial subtraction R - D as R + ~D + 1; the carry out is the no-borrow flag.
    always_comb begin
        rem_shift = {r_q[N-1:0], q_q[N-1]};
        trial_sum = {1'b0, rem_shift} + {1'b0, ~{1'b0, d_q}} + {{(N+1){1'b0}}, 1'b1};
        no_borrow = trial_sum[N+1];
        r_d       = no_borrow ? trial_sum[N:0] : rem_shift;
        q_d       = {q_q[N-2:0], no_borrow};
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the reset clears every register, including the results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            d_q           <= '0;
            q_q           <= '0;
            r_q           <= '0;
            count_q       <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            quotient_q    <= '1;
                            remainder_q   <= bus.dividend;
                            div_by_zero_q <= 1'b1;
                            done_q        <= 1'b1;
                            state_q       <= DONE;
                        end else begin
                            d_q           <= bus.divisor;
                            q_q           <= bus.dividend;
                            r_q           <= '0;
                            count_q       <= CW'(N);
                            div_by_zero_q <= 1'b0;
                            busy_q        <= 1'b1;
                            state_q       <= RUN;
                        end
                    end
                end
                RUN: begin
                    q_q     <= q_d;
                    r_q     <= r_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        quotient_q  <= q_d;
                        remainder_q <= r_d[N-1:0];
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider (N=8): handshake timing, edge operands,
// divide-by-zero, ignored starts, mid-run reset and a short random sweep.
module tb_restoring_divider;
    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    restoring_divider_if #(.N(8)) dif ();

    restoring_divider #(.N(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at #1 after a rising edge with the divider idle; returns likewise.
    task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input string tag);
        int   lat;
        logic busy_ok;
        dif.dividend = a;
        dif.divisor  = b;
        dif.start    = 1'b1;
        @(posedge clk);
        #1;
        dif.start    = 1'b0;
        dif.dividend = 8'h5A;
        dif.divisor  = 8'h00;
        check({tag, " busy_at_accept"}, 32'(dif.busy), 32'(b != 0));
        lat     = 0;
        busy_ok = 1'b1;
        while (dif.done !== 1'b1 && lat < 20) begin
            if (dif.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " done_seen"}, 32'(dif.done), 32'd1);
        check({tag, " latency"}, 32'(lat), (b != 0) ? 32'd8 : 32'd0);
        check({tag, " busy_held"}, 32'(busy_ok), 32'd1);
        check({tag, " busy_at_done"}, 32'(dif.busy), 32'd0);
        check({tag, " quotient"}, 32'(dif.quotient), 32'(eq));
        check({tag, " remainder"}, 32'(dif.remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(dif.div_by_zero), 32'(edbz));
        // A start raised in the done cycle must be ignored.
        dif.dividend = 8'd1;
        dif.divisor  = 8'd1;
        dif.start    = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        check({tag, " done_one_pulse"}, 32'(dif.done), 32'd0);
        check({tag, " start_in_done_ignored"}, 32'(dif.busy), 32'd0);
        check({tag, " quotient_held"}, 32'(dif.quotient), 32'(eq));
    endtask

    initial begin
        int   lat;
        int   extra_done;
        logic [7:0] ra;
        logic [7:0] rb;
        tests        = 0;
        failed       = 0;
        rst_n        = 1'b0;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;

        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset busy", 32'(dif.busy), 32'd0);
        check("reset done", 32'(dif.done), 32'd0);
        check("reset quotient", 32'(dif.quotient), 32'd0);
        check("reset remainder", 32'(dif.remainder), 32'd0);
        check("reset div_by_zero", 32'(dif.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "100/7");
        do_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, "255/1");
        do_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, "5/9");
        do_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, "255/255");
        do_div(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, "0/3");
        do_div(8'd77, 8'd0, 8'd255, 8'd77, 1'b1, "77/0");
        do_div(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, "10/3");

        // Second start during RUN is ignored.
        dif.dividend = 8'd200;
        dif.divisor  = 8'd6;
        dif.start    = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        lat = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            lat++;
        end
        dif.dividend = 8'd9;
        dif.divisor  = 8'd2;
        dif.start    = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        dif.start = 1'b0;
        while (dif.done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("run_start done_seen", 32'(dif.done), 32'd1);
        check("run_start latency", 32'(lat), 32'd8);
        check("run_start quotient", 32'(dif.quotient), 32'd33);
        check("run_start remainder", 32'(dif.remainder), 32'd2);
        extra_done = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (dif.done === 1'b1 || dif.busy === 1'b1) extra_done++;
        end
        check("run_start no_second_op", 32'(extra_done), 32'd0);

        // Reset on cycle 4 of RUN aborts with everything cleared at once.
        dif.dividend = 8'd200;
        dif.divisor  = 8'd6;
        dif.start    = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(dif.busy), 32'd0);
        check("abort done", 32'(dif.done), 32'd0);
        check("abort quotient", 32'(dif.quotient), 32'd0);
        check("abort remainder", 32'(dif.remainder), 32'd0);
        check("abort div_by_zero", 32'(dif.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (dif.done === 1'b1 || dif.busy === 1'b1) extra_done++;
        end
        check("abort no_done", 32'(extra_done), 32'd0);
        do_div(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, "50/5");

        // Random sweep: the expected pair comes from native integer division.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            do_div(ra, rb, ra / rb, ra % rb, 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
